// File: rtl/snake_pkg.sv
// Shared encodings and defaults for the snake game sequencer.
// Includes the tick period and key priority helpers used by the top level.
package snake_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    // Direction codes match key_n bit positions, and reverse(d) == ~d.
    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    localparam int DEF_BASE_PERIOD = 2500000;
    localparam int DEF_STEP        = 250000;
    localparam int DEF_LEVEL_PTS   = 5;
    localparam int DEF_MAX_SCORE   = 99;
    localparam int PERIOD_W        = 32;

    function automatic logic [PERIOD_W-1:0] tick_period(input logic [2:0] lvl,
                                                        input int base,
                                                        input int step_sz);
        int red;
        red = int'(lvl) * step_sz;
        if (base - red < step_sz) begin
            return PERIOD_W'(step_sz);
        end
        return PERIOD_W'(base - red);
    endfunction

    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Bundle of the sequencer's control inputs and status outputs.
// master drives the player/datapath side, slave is the sequencer side.
interface game_sequencer_if;
    logic       start_req;
    logic       pause_req;
    logic [3:0] key_n;
    logic       collision;
    logic       food_eaten;
    logic [1:0] state;
    logic       game_active;
    logic       game_over;
    logic       move_tick;
    logic [1:0] dir;
    logic       clear_req;
    logic [7:0] score;
    logic [2:0] level;

    modport master (
        output start_req, pause_req, key_n, collision, food_eaten,
        input  state, game_active, game_over, move_tick, dir, clear_req, score, level
    );

    modport slave (
        input  start_req, pause_req, key_n, collision, food_eaten,
        output state, game_active, game_over, move_tick, dir, clear_req, score, level
    );
endinterface

// File: rtl/tick_gen.sv
// Programmable step divider: registered one-cycle tick every `period` enabled clocks.
// The period is sampled on load and at each wrap, so changes apply from the next interval.
module tick_gen
    import snake_pkg::*;
#(
    parameter int W = PERIOD_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         load,
    input  logic [W-1:0] period,
    output logic         tick
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] per_q;
    logic         tick_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            per_q  <= '0;
            tick_q <= 1'b0;
        end else if (load) begin
            cnt_q  <= '0;
            per_q  <= period;
            tick_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (enable) begin
                if (cnt_q == per_q - ONE) begin
                    cnt_q  <= '0;
                    per_q  <= period;
                    tick_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + ONE;
                end
            end
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/game_sequencer.sv
// Snake game control: play-state FSM, direction latching, scoring/levels and step pacing.
// Every output comes straight from a register.
module game_sequencer
    import snake_pkg::*;
#(
    parameter int BASE_PERIOD = DEF_BASE_PERIOD,
    parameter int STEP        = DEF_STEP,
    parameter int LEVEL_PTS   = DEF_LEVEL_PTS,
    parameter int MAX_SCORE   = DEF_MAX_SCORE
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       start_req,
    input  logic       pause_req,
    input  logic [3:0] key_n,
    input  logic       collision,
    input  logic       food_eaten,
    output logic [1:0] state,
    output logic       game_active,
    output logic       game_over,
    output logic       move_tick,
    output logic [1:0] dir,
    output logic       clear_req,
    output logic [7:0] score,
    output logic [2:0] level
);
    game_state_t       state_q, state_d;
    logic              start_play;
    logic [1:0]        dir_q;
    logic [1:0]        pend_q;
    logic              pend_vld_q;
    logic [3:0]        key_q;
    logic [3:0]        key_fell;
    logic [7:0]        score_q;
    logic [2:0]        level_q;
    logic [7:0]        food_cnt_q;
    logic              clear_q;
    logic              active_q;
    logic              over_q;
    logic [PERIOD_W-1:0] period;
    logic              tick_en;

    always_comb begin
        state_d    = state_q;
        start_play = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_req) begin
                    state_d    = ST_PLAY;
                    start_play = 1'b1;
                end
            end
            ST_PLAY: begin
                if (collision)      state_d = ST_OVER;
                else if (pause_req) state_d = ST_PAUSE;
            end
            ST_PAUSE: begin
                if (pause_req) state_d = ST_PLAY;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign key_fell = key_q & ~key_n;
    assign period   = tick_period(level_q, BASE_PERIOD, STEP);
    // Counting keyed on the next state keeps ticks out of PAUSE/OVER and holds the count across a pause.
    assign tick_en  = (state_d == ST_PLAY) && !start_play;

    tick_gen #(.W(PERIOD_W)) u_tick (
        .clk    (CLOCK_50),
        .rst_n  (reset_n),
        .enable (tick_en),
        .load   (start_play),
        .period (period),
        .tick   (move_tick)
    );

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_RIGHT;
            pend_q     <= DIR_RIGHT;
            pend_vld_q <= 1'b0;
            key_q      <= 4'hF;
            score_q    <= '0;
            level_q    <= '0;
            food_cnt_q <= '0;
            clear_q    <= 1'b0;
            active_q   <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            clear_q  <= start_play;
            active_q <= (state_d == ST_PLAY) || (state_d == ST_PAUSE);
            over_q   <= (state_d == ST_OVER);
            key_q    <= key_n;
            if (start_play) begin
                score_q    <= '0;
                level_q    <= '0;
                food_cnt_q <= '0;
                dir_q      <= DIR_RIGHT;
                pend_vld_q <= 1'b0;
            end else if (state_q == ST_PLAY) begin
                if (food_eaten && !collision) begin
                    if (score_q < 8'(MAX_SCORE)) score_q <= score_q + 8'd1;
                    if (food_cnt_q >= 8'(LEVEL_PTS - 1)) begin
                        food_cnt_q <= '0;
                        if (level_q != 3'd7) level_q <= level_q + 3'd1;
                    end else begin
                        food_cnt_q <= food_cnt_q + 8'd1;
                    end
                end
                if (move_tick && pend_vld_q) begin
                    if (pend_q != ~dir_q) dir_q <= pend_q;
                    pend_vld_q <= 1'b0;
                end
                // A fresh key edge wins over consuming the old request in the same cycle.
                if (|key_fell) begin
                    pend_q     <= lowest_set(key_fell);
                    pend_vld_q <= 1'b1;
                end
            end
        end
    end

    assign state       = state_q;
    assign game_active = active_q;
    assign game_over   = over_q;
    assign dir         = dir_q;
    assign clear_req   = clear_q;
    assign score       = score_q;
    assign level       = level_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with BASE_PERIOD=20, STEP=2, LEVEL_PTS=2, MAX_SCORE=5.
module tb_game_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    game_sequencer_if gs ();

    game_sequencer #(
        .BASE_PERIOD(20), .STEP(2), .LEVEL_PTS(2), .MAX_SCORE(5)
    ) dut (
        .CLOCK_50   (clk),
        .reset_n    (reset_n),
        .start_req  (gs.start_req),
        .pause_req  (gs.pause_req),
        .key_n      (gs.key_n),
        .collision  (gs.collision),
        .food_eaten (gs.food_eaten),
        .state      (gs.state),
        .game_active(gs.game_active),
        .game_over  (gs.game_over),
        .move_tick  (gs.move_tick),
        .dir        (gs.dir),
        .clear_req  (gs.clear_req),
        .score      (gs.score),
        .level      (gs.level)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until move_tick is seen; n is the number of steps taken (bounded).
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!gs.move_tick && n < 200);
    endtask

    task automatic test_reset();
        gs.start_req = 0; gs.pause_req = 0; gs.key_n = 4'hF;
        gs.collision = 0; gs.food_eaten = 0;
        reset_n = 0;
        step(); step();
        checks++;
        if ({gs.state, gs.game_active, gs.game_over, gs.move_tick, gs.clear_req} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got state=%0d act=%0d over=%0d tick=%0d clr=%0d want all 0",
                     gs.state, gs.game_active, gs.game_over, gs.move_tick, gs.clear_req);
        end
        checks++;
        if ({gs.score, gs.level, gs.dir} !== 13'd0) begin
            errors++;
            $display("FAIL reset_counts: got score=%0d level=%0d dir=%0d want 0 0 0", gs.score, gs.level, gs.dir);
        end
        #3 reset_n = 1;
        step();
        // Key edge in IDLE must be ignored.
        gs.key_n = 4'b1101; step(); gs.key_n = 4'hF; step();
        $display("test_reset: state=%0d score=%0d", gs.state, gs.score);
    endtask

    task automatic test_start();
        int m;
        gs.start_req = 1; gs.pause_req = 1;
        step();
        gs.start_req = 0; gs.pause_req = 0;
        checks++;
        if (gs.state !== 2'd1) begin errors++; $display("FAIL start_state: got %0d want 1", gs.state); end
        checks++;
        if (gs.clear_req !== 1'b1) begin errors++; $display("FAIL start_clear: got %0d want 1", gs.clear_req); end
        checks++;
        if (gs.game_active !== 1'b1) begin errors++; $display("FAIL start_active: got %0d want 1", gs.game_active); end
        step();
        checks++;
        if (gs.clear_req !== 1'b0) begin errors++; $display("FAIL start_clear_len: got %0d want 0", gs.clear_req); end
        wait_tick(m);
        checks++;
        if (m + 1 !== 20) begin errors++; $display("FAIL first_tick: got %0d cycles want 20", m + 1); end
        wait_tick(m);
        checks++;
        if (m !== 20) begin errors++; $display("FAIL tick_period: got %0d want 20", m); end
        step();
        checks++;
        if (gs.dir !== 2'd0) begin errors++; $display("FAIL idle_key_ignored: got dir=%0d want 0", gs.dir); end
        $display("test_start: first tick after %0d, period %0d", 20, m);
    endtask

    task automatic test_direction();
        int m;
        wait_tick(m);
        gs.key_n = 4'b0111; step(); gs.key_n = 4'hF; step();
        wait_tick(m);
        checks++;
        if (m !== 18) begin errors++; $display("FAIL dir_tick_a: got %0d want 18", m); end
        step();
        checks++;
        if (gs.dir !== 2'd0) begin errors++; $display("FAIL reverse_reject: got dir=%0d want 0", gs.dir); end
        gs.key_n = 4'b1101; step(); gs.key_n = 4'hF; step();
        wait_tick(m);
        step();
        checks++;
        if (gs.dir !== 2'd1) begin errors++; $display("FAIL dir_down: got dir=%0d want 1", gs.dir); end
        gs.key_n = 4'b0110; step(); gs.key_n = 4'hF; step();
        wait_tick(m);
        step();
        checks++;
        if (gs.dir !== 2'd0) begin errors++; $display("FAIL lowest_wins: got dir=%0d want 0", gs.dir); end
        gs.key_n = 4'b1101; step(); gs.key_n = 4'hF; step();
        gs.key_n = 4'b1011; step(); gs.key_n = 4'hF; step();
        wait_tick(m);
        checks++;
        if (m !== 15) begin errors++; $display("FAIL dir_tick_b: got %0d want 15", m); end
        step();
        checks++;
        if (gs.dir !== 2'd2) begin errors++; $display("FAIL overwrite: got dir=%0d want 2", gs.dir); end
        $display("test_direction: dir=%0d", gs.dir);
    endtask

    task automatic test_pause();
        int m;
        int ticks;
        wait_tick(m);
        checks++;
        if (m !== 19) begin errors++; $display("FAIL pre_pause_tick: got %0d want 19", m); end
        repeat (7) step();
        gs.pause_req = 1; step(); gs.pause_req = 0;
        checks++;
        if (gs.state !== 2'd2) begin errors++; $display("FAIL pause_state: got %0d want 2", gs.state); end
        ticks = 0;
        gs.key_n = 4'b0111; step(); if (gs.move_tick) ticks++;
        gs.key_n = 4'hF;    step(); if (gs.move_tick) ticks++;
        gs.food_eaten = 1;  step(); if (gs.move_tick) ticks++;
        gs.food_eaten = 0;
        repeat (25) begin step(); if (gs.move_tick) ticks++; end
        checks++;
        if (ticks !== 0) begin errors++; $display("FAIL pause_ticks: got %0d want 0", ticks); end
        checks++;
        if (gs.score !== 8'd0) begin errors++; $display("FAIL pause_food: got score=%0d want 0", gs.score); end
        gs.pause_req = 1; step(); gs.pause_req = 0;
        checks++;
        if (gs.state !== 2'd1 || gs.clear_req !== 1'b0) begin
            errors++;
            $display("FAIL resume: got state=%0d clr=%0d want 1 0", gs.state, gs.clear_req);
        end
        wait_tick(m);
        checks++;
        if (m + 1 !== 13) begin errors++; $display("FAIL resume_tick: got %0d want 13", m + 1); end
        step();
        checks++;
        if (gs.dir !== 2'd2) begin errors++; $display("FAIL pause_key_ignored: got dir=%0d want 2", gs.dir); end
        $display("test_pause: resume tick after %0d", m + 1);
    endtask

    task automatic test_play_priority();
        gs.start_req = 1; gs.pause_req = 1; step();
        gs.start_req = 0; gs.pause_req = 0;
        checks++;
        if (gs.state !== 2'd2 || gs.clear_req !== 1'b0) begin
            errors++;
            $display("FAIL pause_over_start: got state=%0d clr=%0d want 2 0", gs.state, gs.clear_req);
        end
        gs.pause_req = 1; step(); gs.pause_req = 0;
        gs.collision = 1; gs.pause_req = 1; step();
        gs.collision = 0; gs.pause_req = 0;
        checks++;
        if (gs.state !== 2'd3 || gs.game_over !== 1'b1 || gs.game_active !== 1'b0) begin
            errors++;
            $display("FAIL collide_over_pause: got state=%0d over=%0d act=%0d want 3 1 0",
                     gs.state, gs.game_over, gs.game_active);
        end
        $display("test_play_priority: state=%0d", gs.state);
    endtask

    task automatic test_collision();
        gs.start_req = 1; step(); gs.start_req = 0;
        repeat (2) begin gs.food_eaten = 1; step(); gs.food_eaten = 0; step(); end
        gs.collision = 1; gs.food_eaten = 1; step();
        gs.collision = 0; gs.food_eaten = 0;
        checks++;
        if (gs.state !== 2'd3 || gs.score !== 8'd2 || gs.level !== 3'd1) begin
            errors++;
            $display("FAIL collide_food: got state=%0d score=%0d level=%0d want 3 2 1", gs.state, gs.score, gs.level);
        end
        gs.food_eaten = 1; step(); gs.food_eaten = 0; step(); step();
        checks++;
        if (gs.score !== 8'd2) begin errors++; $display("FAIL over_hold: got score=%0d want 2", gs.score); end
        gs.start_req = 1; step(); gs.start_req = 0;
        checks++;
        if (gs.state !== 2'd1 || gs.score !== 8'd0 || gs.level !== 3'd0 || gs.clear_req !== 1'b1) begin
            errors++;
            $display("FAIL restart: got state=%0d score=%0d level=%0d clr=%0d want 1 0 0 1",
                     gs.state, gs.score, gs.level, gs.clear_req);
        end
        $display("test_collision: restart score=%0d", gs.score);
    endtask

    task automatic test_scoring();
        logic [7:0] exp_s [6] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd5};
        logic [2:0] exp_l [6] = '{3'd0, 3'd1, 3'd1, 3'd2, 3'd2, 3'd3};
        int m;
        for (int i = 0; i < 6; i++) begin
            gs.food_eaten = 1; step(); gs.food_eaten = 0;
            checks++;
            if (gs.score !== exp_s[i] || gs.level !== exp_l[i]) begin
                errors++;
                $display("FAIL food_%0d: got score=%0d level=%0d want %0d %0d",
                         i + 1, gs.score, gs.level, exp_s[i], exp_l[i]);
            end
        end
        wait_tick(m);
        wait_tick(m);
        checks++;
        if (m !== 14) begin errors++; $display("FAIL level3_period: got %0d want 14", m); end
        gs.collision = 1; step(); gs.collision = 0; step();
        checks++;
        if (gs.state !== 2'd3 || gs.score !== 8'd5 || gs.level !== 3'd3) begin
            errors++;
            $display("FAIL over_keep: got state=%0d score=%0d level=%0d want 3 5 3", gs.state, gs.score, gs.level);
        end
        $display("test_scoring: score=%0d level=%0d period=%0d", gs.score, gs.level, m);
    endtask

    task automatic test_reset_mid_play();
        int m;
        gs.start_req = 1; step(); gs.start_req = 0;
        gs.food_eaten = 1; step(); gs.food_eaten = 0;
        repeat (3) step();
        gs.key_n = 4'b1101;
        #3 reset_n = 0;
        #1;
        checks++;
        if ({gs.state, gs.game_active, gs.game_over, gs.move_tick, gs.clear_req} !== 6'b0 ||
            {gs.score, gs.level, gs.dir} !== 13'd0) begin
            errors++;
            $display("FAIL async_reset: got state=%0d act=%0d over=%0d score=%0d level=%0d want 0 0 0 0 0",
                     gs.state, gs.game_active, gs.game_over, gs.score, gs.level);
        end
        step();
        checks++;
        if (gs.clear_req !== 1'b0) begin errors++; $display("FAIL reset_no_clear: got %0d want 0", gs.clear_req); end
        #4 reset_n = 1;
        step();
        gs.start_req = 1; step(); gs.start_req = 0;
        gs.key_n = 4'hF;
        wait_tick(m);
        step();
        checks++;
        if (gs.dir !== 2'd0) begin errors++; $display("FAIL post_reset_key: got dir=%0d want 0", gs.dir); end
        $display("test_reset_mid_play: dir=%0d", gs.dir);
    endtask

    initial begin
        test_reset();
        test_start();
        test_direction();
        test_pause();
        test_play_priority();
        test_collision();
        test_scoring();
        test_reset_mid_play();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter BASE_PERIOD, default 2500000, meaning move_tick period in clocks at level 0.
REQ-002 SHALL have parameter STEP, default 250000, meaning period reduction in clocks per level.
REQ-003 SHALL have parameter LEVEL_PTS, default 5, meaning foods eaten per level increment.
REQ-004 SHALL have parameter MAX_SCORE, default 99, meaning score saturation value.
REQ-005 SHALL have port CLOCK_50, input, 1 bit: the single clock; one clock, all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start_req, input, 1 bit: active-high start pulse.
REQ-008 SHALL have port pause_req, input, 1 bit: active-high pause/resume pulse.
REQ-009 SHALL have port key_n, input, 4 bits: debounced direction buttons, active-low; [0]=right, [1]=down, [2]=up, [3]=left.
REQ-010 SHALL have port collision, input, 1 bit: head hit a wall or the body (level).
REQ-011 SHALL have port food_eaten, input, 1 bit: one-cycle pulse.
REQ-012 SHALL have port state, output, 2 bits: IDLE=0, PLAY=1, PAUSE=2, OVER=3.
REQ-013 SHALL have port game_active, output, 1 bit: high when state is PLAY or PAUSE.
REQ-014 SHALL have port game_over, output, 1 bit: high when state is OVER.
REQ-015 SHALL have port move_tick, output, 1 bit: one-cycle step pulse to the snake datapath.
REQ-016 SHALL have port dir, output, 2 bits: current direction, encoded right=0, down=1, up=2, left=3.
REQ-017 SHALL have port clear_req, output, 1 bit: one-cycle pulse that reinitialises the snake and food.
REQ-018 SHALL have port score, output, 8 bits: binary score.
REQ-019 SHALL have port level, output, 3 bits: speed level, 0..7.

Function
REQ-020 FSM transitions SHALL be:
- IDLE -> PLAY on start_req.
- PLAY -> PAUSE on pause_req.
- PAUSE -> PLAY on pause_req.
- PLAY -> OVER on collision.
- OVER -> PLAY on start_req.
- No other transitions.
REQ-021 Every entry into PLAY from IDLE or OVER SHALL, on the transition edge:
- pulse clear_req for exactly 1 cycle;
- zero score, level, the food sub-counter and the tick counter;
- set dir=right and clear the pending direction.
REQ-022 Resuming from PAUSE SHALL NOT pulse clear_req and SHALL keep the tick counter value.
REQ-023 In PAUSE, the tick counter SHALL hold and move_tick SHALL stay 0.
REQ-024 The tick counter SHALL run only in PLAY.
REQ-025 move_tick SHALL be 1 for one cycle when the counter reaches period-1; the counter then wraps to 0.
REQ-026 The period SHALL be BASE_PERIOD - level*STEP, floored at STEP.
REQ-027 The period SHALL be re-evaluated at each wrap, so a level change takes effect from the next interval.
REQ-028 A falling edge on key_n[i] SHALL load a pending direction.
REQ-029 If several bits fall in the same cycle, the lowest index SHALL win.
REQ-030 Direction edges SHALL be detected in PLAY only; they are ignored in IDLE, PAUSE and OVER.
REQ-031 On move_tick, dir SHALL take the pending value unless it is the exact reverse of dir; a reverse request is discarded.
REQ-032 A later key edge within the same tick interval SHALL overwrite the pending value.
REQ-033 On food_eaten in PLAY:
- score increments, saturating at MAX_SCORE;
- the food sub-counter increments;
- at LEVEL_PTS the sub-counter wraps to 0 and level increments, saturating at 7.
REQ-034 food_eaten outside PLAY SHALL be ignored.
REQ-035 If collision and food_eaten occur in the same cycle, collision SHALL win: go to OVER with score unchanged.
REQ-036 If start_req and pause_req occur in the same cycle in IDLE or OVER, start_req SHALL win.
REQ-037 In PLAY, pause_req SHALL take priority over a same-cycle start_req, which is ignored.
REQ-038 If collision and pause_req occur in the same cycle in PLAY, collision SHALL win.
REQ-039 score and level SHALL hold their values in OVER until the next start.
REQ-040 All outputs SHALL be registered.
REQ-041 move_tick SHALL appear one cycle after the counter compare.
REQ-042 clear_req SHALL coincide with the first cycle in which state=PLAY.

Reset
REQ-043 With reset_n low, asynchronously: state=IDLE, dir=right, pending direction cleared, all counters 0.
REQ-044 With reset_n low, outputs SHALL be: move_tick=0, clear_req=0, score=0, level=0, game_active=0, game_over=0.
REQ-045 Reset asserted mid-PLAY SHALL abort immediately, with no clear_req pulse.
REQ-046 The key edge detector SHALL initialise to all-ones (released), so no spurious edge occurs after reset.

Structure
REQ-047 The state encoding, direction encoding and default parameter values SHALL live in a shared package, snake_pkg.
REQ-048 The tick divider SHALL be one sub-module, tick_gen, with ports: enable, load, period, tick.

Verification
REQ-049 Bench parameters SHALL be BASE_PERIOD=20, STEP=2, LEVEL_PTS=2, MAX_SCORE=5.
REQ-050 Start: start_req in IDLE -> state=1 and clear_req=1 for exactly 1 cycle; first move_tick 20 cycles later, then every 20 cycles.
REQ-051 Reverse rejection: dir=right, press key_n[3] -> dir stays 0 at the next tick. Press key_n[1] -> dir=1 at the following tick.
REQ-052 Scoring: 6 food_eaten pulses -> score=5 (saturated), level=3, tick period 14.
REQ-053 Collision priority: collision and food_eaten in the same cycle with score=2 -> state=3, score=2. Then start_req -> state=1, score=0, clear_req pulses.
REQ-054 Pause: pause_req at counter=7 -> no ticks during PAUSE; after resume, the next tick arrives 13 cycles later, with no clear_req.
REQ-055 Reset: reset_n low mid-PLAY, asynchronous to the clock -> all outputs at reset values in the same cycle; no key edge detected on release.
